// File: rtl/vga_pattern_gen_if.sv
// Bundle between the VGA timing generator, the pattern generator and the output pins.
// The master side drives timing and controls; the slave side returns registered RGB and syncs.
interface vga_pattern_gen_if #(
  parameter int unsigned CW      = 4,
  parameter int unsigned XW      = 11,
  parameter int unsigned SPEED_W = 4
);
  logic [XW-1:0]      x;
  logic [XW-1:0]      y;
  logic               de;
  logic               hsync;
  logic               vsync;
  logic [2:0]         mode;
  logic [SPEED_W-1:0] speed;
  logic               pause;
  logic [CW-1:0]      r;
  logic [CW-1:0]      g;
  logic [CW-1:0]      b;
  logic               de_o;
  logic               hsync_o;
  logic               vsync_o;

  modport master (
    output x, y, de, hsync, vsync, mode, speed, pause,
    input  r, g, b, de_o, hsync_o, vsync_o
  );

  modport slave (
    input  x, y, de, hsync, vsync, mode, speed, pause,
    output r, g, b, de_o, hsync_o, vsync_o
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Selectable VGA test patterns with per-frame horizontal scroll.
// Two register stages; syncs travel alongside the pixel data so all outputs share one latency.
module vga_pattern_gen #(
  parameter int unsigned CW       = 4,
  parameter int unsigned XW       = 11,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SPEED_W  = 4,
  parameter int unsigned SQ_LOG2  = 5
) (
  input logic              clk,
  input logic              rst_n,
  vga_pattern_gen_if.slave bus
);
  localparam int unsigned   PW   = XW + CW;
  localparam logic [CW-1:0] Max  = {CW{1'b1}};
  localparam logic [XW:0]   HAct = (XW+1)'(H_ACTIVE);
  localparam logic [XW-1:0] VAct = XW'(V_ACTIVE);
  localparam logic [PW-1:0] MaxP = PW'((1 << CW) - 1);
  localparam logic [PW-1:0] HDiv = PW'(H_ACTIVE - 1);
  localparam logic [PW-1:0] VDiv = PW'(V_ACTIVE - 1);
  localparam logic [PW-1:0] BarW = PW'(H_ACTIVE / 8);

  // Frame-boundary state
  logic          vsync_d_q;
  logic          armed_q;
  logic          fe;
  logic [2:0]    mode_q;
  logic [XW-1:0] offset_q;
  logic [XW-1:0] offset_d;
  logic [XW:0]   off_sum;
  logic [XW:0]   x_sum;
  logic [XW-1:0] xm;
  logic          in_range;

  // Stage 1
  logic [XW-1:0] xm_q;
  logic [XW-1:0] y_q;
  logic          valid_q;
  logic          de_s1_q;
  logic          hs_s1_q;
  logic          vs_s1_q;
  logic [2:0]    mode_s1_q;

  // Stage 2
  logic [CW-1:0]     hl;
  logic [CW-1:0]     vl;
  logic [2:0]        bar;
  logic              chk;
  logic [3*CW-1:0]   rgb_d;
  logic [3*CW-1:0]   rgb_q;
  logic              de_o_q;
  logic              hs_o_q;
  logic              vs_o_q;

  always_comb begin
    // armed_q blocks a spurious edge when vsync is already high on reset release
    fe       = bus.vsync & ~vsync_d_q & armed_q;
    off_sum  = {1'b0, offset_q} + (XW+1)'(bus.speed);
    offset_d = (off_sum >= HAct) ? off_sum[XW-1:0] - HAct[XW-1:0] : off_sum[XW-1:0];
    x_sum    = {1'b0, bus.x} + {1'b0, offset_q};
    xm       = (x_sum >= HAct) ? x_sum[XW-1:0] - HAct[XW-1:0] : x_sum[XW-1:0];
    in_range = bus.de & ({1'b0, bus.x} < HAct) & (bus.y < VAct);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_q <= 1'b0;
      armed_q   <= 1'b0;
      mode_q    <= '0;
      offset_q  <= '0;
    end else begin
      vsync_d_q <= bus.vsync;
      armed_q   <= armed_q | ~bus.vsync;
      if (fe) begin
        mode_q <= bus.mode;
        if (!bus.pause) offset_q <= offset_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xm_q      <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      de_s1_q   <= 1'b0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      mode_s1_q <= '0;
    end else begin
      xm_q      <= xm;
      y_q       <= bus.y;
      valid_q   <= in_range;
      de_s1_q   <= bus.de;
      hs_s1_q   <= bus.hsync;
      vs_s1_q   <= bus.vsync;
      mode_s1_q <= mode_q;
    end
  end

  always_comb begin
    hl    = CW'(({{CW{1'b0}}, xm_q} * MaxP) / HDiv);
    vl    = CW'(({{CW{1'b0}}, y_q} * MaxP) / VDiv);
    bar   = 3'({{CW{1'b0}}, xm_q} / BarW);
    chk   = xm_q[SQ_LOG2] ^ y_q[SQ_LOG2];
    rgb_d = '0;
    if (valid_q) begin
      case (mode_s1_q)
        3'd0:    rgb_d = {hl, vl, Max - hl};
        // White, yellow, cyan, green, magenta, red, blue, black
        3'd1:    rgb_d = {{CW{~bar[1]}}, {CW{~bar[2]}}, {CW{~bar[0]}}};
        3'd2:    rgb_d = {(3*CW){chk}};
        3'd3:    rgb_d = {(3*CW){1'b1}};
        default: rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q  <= '0;
      de_o_q <= 1'b0;
      hs_o_q <= 1'b0;
      vs_o_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      de_o_q <= de_s1_q;
      hs_o_q <= hs_s1_q;
      vs_o_q <= vs_s1_q;
    end
  end

  assign bus.r       = rgb_q[3*CW-1:2*CW];
  assign bus.g       = rgb_q[2*CW-1:CW];
  assign bus.b       = rgb_q[CW-1:0];
  assign bus.de_o    = de_o_q;
  assign bus.hsync_o = hs_o_q;
  assign bus.vsync_o = vs_o_q;
endmodule
